// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit.
//   One radix-2 step per CALC cycle: shift-add multiply (2*DATA_WIDTH-bit
//   product) or restoring shift-subtract divide, DATA_WIDTH cycles per op.
//   Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow
//   (most-negative / -1) finish at acceptance and skip CALC entirely.
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset, aborts any operation
//   start  - request; accepted in IDLE or DONE only
//   op     - RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b   - rs1 / rs2 operands, captured at acceptance
//   result - registered result, held until the next operation completes
//   busy   - high while iterating (CALC)
//   done   - one-cycle pulse in DONE
module muldiv_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    state_e         state, state_next;
    op_e            op_in, op_r;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mag_a, mag_b;
    logic           neg_q, neg_r, div0;
    logic [W-1:0]   acc_hi, acc_lo;

    logic           accept, last, early;
    logic           sign_a_in, sign_b_in, div0_in;
    logic [W-1:0]   mag_a_in, mag_b_in;

    logic           is_div;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic           div_ok;
    logic [W-1:0]   next_hi, next_lo;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, final_res;

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    logic           ovf_in;
    logic [W-1:0]   special_res;
`endif

    // ---------------- acceptance-side decode ----------------
    always_comb begin
        op_in     = op_e'(op);
        accept    = start && (state == S_IDLE || state == S_DONE);
        sign_a_in = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a[W-1];
        sign_b_in = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && b[W-1];
        mag_a_in  = sign_a_in ? -a : a;
        mag_b_in  = sign_b_in ? -b : b;
        div0_in   = op[2] && (b == '0);
`ifdef MULDIV_EARLY_OUT_EN
        ovf_in      = (op_in inside {OP_DIV, OP_REM}) && (a == MIN_VAL) && (b == '1);
        early       = div0_in || ovf_in;
        // op[1] separates REM/REMU from DIV/DIVU
        special_res = op[1] ? (div0_in ? a : '0) : (div0_in ? '1 : a);
`else
        early       = 1'b0;
`endif
    end

    // ---------------- one iteration step ----------------
    always_comb begin
        is_div    = op_r inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        last      = (cnt == CW'(W - 1));
        // multiply: acc_lo holds the multiplier, shifted out LSB first
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
        // divide: acc_hi is the partial remainder, acc_lo dividend/quotient
        div_shift = {acc_hi, acc_lo[W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ok    = !div_diff[W];
        if (is_div) begin
            next_hi = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
            next_lo = {acc_lo[W-2:0], div_ok};
        end else begin
            next_hi = mul_sum[W:1];
            next_lo = {mul_sum[0], acc_lo[W-1:1]};
        end
    end

    // ---------------- sign correction and result select ----------------
    // Applied to the final step's combinational values so the result is
    // written on the same edge as the last iteration.
    always_comb begin
        prod     = {next_hi, next_lo};
        prod_fix = neg_q ? -prod : prod;
        quot_fix = div0 ? '1 : (neg_q ? -next_lo : next_lo);
        rem_fix  = div0 ? (neg_r ? -mag_a : mag_a) : (neg_r ? -next_hi : next_hi);
        unique case (op_r)
            OP_MUL:                       final_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:              final_res = quot_fix;
            default:                      final_res = rem_fix;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (accept) state_next = early ? S_DONE : S_CALC;
            S_CALC: if (last)   state_next = S_DONE;
            S_DONE: begin
                if (accept) state_next = early ? S_DONE : S_CALC;
                else        state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_CALC);
        done = (state == S_DONE);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r   <= OP_MUL;
            cnt    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            result <= '0;
        end else if (accept) begin
            op_r   <= op_in;
            cnt    <= '0;
            mag_a  <= mag_a_in;
            mag_b  <= mag_b_in;
            neg_q  <= sign_a_in ^ sign_b_in;
            neg_r  <= sign_a_in;
            div0   <= div0_in;
            acc_hi <= '0;
            acc_lo <= op[2] ? mag_a_in : mag_b_in;
`ifdef MULDIV_EARLY_OUT_EN
            if (early) result <= special_res;
`endif
        end else if (state == S_CALC) begin
            acc_hi <= next_hi;
            acc_lo <= next_lo;
            cnt    <= cnt + CW'(1);
            if (last) result <= final_res;
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    muldiv_iter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    logic [31:0] exp_hold = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] p;
        int          ix, iy;
        logic        ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        ix  = $signed(x);
        iy  = $signed(y);
        case (o)
            3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
            3'd1: begin sx = longint'($signed(x)); sy = longint'($signed(y)); p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin sx = longint'($signed(x)); sy = longint'({32'd0, y}); p = 64'(sx * sy); return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(ix / iy);
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : ovf ? 32'd0 : 32'(ix % iy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic special;
        special = o[2] && ((y == 0) ||
                  ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        return (EARLY && special) ? 0 : 32;
    endfunction

    // Compare process: every completion must match the queued model value,
    // and the result must hold its last value on every other cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst === 1'b0) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_result", {32'd0, result}, {32'd0, e});
                    exp_hold = e;
                end
            end else begin
                chk("held_result", {32'd0, result}, {32'd0, exp_hold});
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] lit, input bit pulse);
        int lat, first_done, busy_cnt, done_cnt, bad_busy;
        lat = latency(o, x, y);
        first_done = 0; busy_cnt = 0; done_cnt = 0; bad_busy = 0;
        chk("model_pin", {32'd0, model(o, x, y)}, {32'd0, lit});
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(model(o, x, y));
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        for (int c = 1; c <= lat + 3; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
            if (busy) begin
                busy_cnt++;
                if (c > lat) bad_busy++;
            end
            if (pulse && c == 10) begin start = 1'b1; op = 3'd3; a = $urandom; b = $urandom; end
            if (pulse && c == 11) start = 1'b0;
            @(posedge clk); #1;
        end
        chk("done_cycle", 64'(first_done), 64'(lat + 1));
        chk("busy_cycles", 64'(busy_cnt), 64'(lat));
        chk("busy_window", 64'(bad_busy), 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("final_result", {32'd0, result}, {32'd0, lit});
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x, y, lit;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int d1, d2, dc;
        vecs = '{
            '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
            '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF,  32'h0000_0002, 32'hFFFF_FFFF},
            '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
            '{3'd5, 32'd100,        32'd7,         32'd14},
            '{3'd7, 32'd100,        32'd7,         32'd2},
            '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
            '{3'd6, 32'd5,          32'd0,         32'd5},
            '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
            '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF},
            '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9},
            '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0},
            '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1}
        };

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result", {32'd0, result}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // directed vectors; the first one also pulses start mid-CALC
        foreach (vecs[i]) run_op(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].lit, i == 0);

        // reset during CALC cycle 10 aborts without a done pulse
        start = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
        exp_q.push_back(model(3'd3, a, b));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_hold = '0;
        @(negedge clk);
        chk("abort_result", {32'd0, result}, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        dc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("abort_no_done", 64'(dc), 64'd0);
        @(posedge clk); #1;
        run_op(3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, 1'b0);

        // start held high across DONE: back-to-back operations
        d1 = 0; d2 = 0; dc = 0;
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD;
        exp_q.push_back(model(op, a, b));
        @(posedge clk); #1;
        op = 3'd5; a = 32'd100; b = 32'd7;
        exp_q.push_back(model(op, a, b));
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (done) begin
                dc++;
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
            @(posedge clk); #1;
            if (c == 33) start = 1'b0;
        end
        chk("b2b_first_done", 64'(d1), 64'd33);
        chk("b2b_second_done", 64'(d2), 64'd66);
        chk("b2b_pulses", 64'(dc), 64'd2);
        chk("b2b_result", {32'd0, result}, 64'd14);
        chk("b2b_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width, even, >= 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled in IDLE or DONE only.
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port a  input  DATA_WIDTH  operand rs1 (dividend/multiplicand).
REQ-007 SHALL have port b  input  DATA_WIDTH  operand rs2 (divisor/multiplier).
REQ-008 SHALL have port result  output  DATA_WIDTH  registered result, held until next accepted start.
REQ-009 SHALL have port busy  output  1  high in CALC.
REQ-010 SHALL have port done  output  1  one-cycle pulse, high only in DONE.

Function
REQ-011 SHALL implement states IDLE, CALC, DONE; IDLE->CALC and DONE->CALC on start; CALC->DONE after the last iteration; DONE->IDLE when start is low.
REQ-012 SHALL, on accepting start, capture a, b and op in internal registers; later input changes have no effect.
REQ-013 SHALL convert signed operands to magnitudes at acceptance (both for MULH/DIV/REM, a only for MULHSU) and record result sign.
REQ-014 SHALL perform one radix-2 iteration per CALC cycle: shift-add for multiply (2*DATA_WIDTH product), restoring shift-subtract for divide.
REQ-015 SHALL run exactly DATA_WIDTH CALC cycles; done is high in cycle DATA_WIDTH+1 counting the acceptance edge as edge 0.
REQ-016 SHALL apply sign correction on the CALC->DONE edge: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-017 SHALL select result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
REQ-018 SHALL, for divide by zero, return all-ones quotient (DIV and DIVU) and remainder = a (REM and REMU).
REQ-019 SHALL, for DIV/REM with a = most-negative value and b = all-ones, return quotient = a and remainder = 0.
REQ-020 SHALL ignore start while in CALC; no queueing.
REQ-021 SHALL, on start during DONE, still pulse done that cycle and enter CALC next edge (back-to-back ops).
REQ-022 SHALL keep result unchanged through CALC until the DONE edge updates it.

Reset
REQ-023 SHALL, when rst is high at a rising edge, enter IDLE, clear result to 0, busy to 0, done to 0, and clear all counters and internal registers.
REQ-024 SHALL abort an in-flight operation on rst with no done pulse; rst has priority over start on the same edge.

Configuration
REQ-025 SHALL support macro MULDIV_EARLY_OUT_EN.
REQ-026 SHALL, with MULDIV_EARLY_OUT_EN defined, skip CALC for divide-by-zero and signed-overflow cases (REQ-018/019): done high in cycle 1 after acceptance with the special result.
REQ-027 SHALL, without MULDIV_EARLY_OUT_EN, run every operation the full DATA_WIDTH iterations (fixed latency, REQ-015).

Verification
REQ-028 SHALL test MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 33, busy high cycles 1-32.
REQ-029 SHALL test MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-030 SHALL test DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-031 SHALL test DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; done in cycle 1 with MULDIV_EARLY_OUT_EN, cycle 33 without.
REQ-032 SHALL test rst asserted at CALC cycle 10 -> IDLE next edge, result 0, no done; new start afterwards completes normally.
REQ-033 SHALL test start held high across DONE -> two consecutive done pulses 33 cycles apart; start pulsed in CALC ignored.
